// File: rtl/mult8x8_err_acc_if.sv
// rtl/mult8x8_err_acc_if.sv - sample handshake bus between a multiplier under test and its error accumulator
interface mult8x8_err_acc_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] in_r;

  modport master (output in_valid, output in_a, output in_b, output in_r, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, input in_r, output in_ready);
endinterface

// File: rtl/mult8x8_err_acc.sv
// rtl/mult8x8_err_acc.sv - accumulates abs/max error, mismatch and over-estimate counts of an approximate 8x8 multiplier
// Stage 1 registers the accepted sample, stage 2 recomputes the exact product and updates the results.
module mult8x8_err_acc #(
  parameter int N_SAMPLES = 256,
  parameter int SUM_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  mult8x8_err_acc_if.slave smp,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [15:0]      max_abs_err,
  output logic [15:0]      err_count,
  output logic [15:0]      over_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        cnt;
  logic               rdy;
  logic               accept;
  logic               v1;
  logic [7:0]         a1;
  logic [7:0]         b1;
  logic [15:0]        r1;
  logic [15:0]        exact;
  logic [15:0]        mag;
  logic signed [16:0] diff;
  logic [SUM_W:0]     sum_ext;

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (smp.in_valid && cnt == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign smp.in_ready = rdy;
  assign accept       = smp.in_valid & rdy;

  assign exact   = a1 * b1;
  assign diff    = $signed({1'b0, r1}) - $signed({1'b0, exact});
  assign mag     = diff[16] ? 16'(-diff) : diff[15:0];
  // One extra bit catches the carry that signals saturation.
  assign sum_ext = {1'b0, sum_abs_err} + {{(SUM_W - 15){1'b0}}, mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      v1          <= 1'b0;
      a1          <= '0;
      b1          <= '0;
      r1          <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
      over_count  <= '0;
    end else begin
      state <= state_nxt;
      v1    <= accept;
      if (accept) begin
        a1  <= smp.in_a;
        b1  <= smp.in_b;
        r1  <= smp.in_r;
        cnt <= cnt + 16'd1;
      end
      if (state == IDLE && start) begin
        cnt         <= '0;
        sum_abs_err <= '0;
        max_abs_err <= '0;
        err_count   <= '0;
        over_count  <= '0;
      end else if (v1) begin
        sum_abs_err <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (mag > max_abs_err) max_abs_err <= mag;
        err_count   <= err_count + {15'd0, (mag != 16'd0)};
        over_count  <= over_count + {15'd0, (r1 > exact)};
      end
    end
  end
endmodule

// File: doc/mult8x8_err_acc.md
# mult8x8_err_acc

Sequential error-characterisation stage that sits directly downstream of an approximate 8x8 multiplier. It consumes the operands and the approximate 16-bit product over a valid/ready handshake and recomputes the exact product internally. Over a run of N_SAMPLES accepted samples it accumulates sum of absolute error, maximum absolute error, mismatch count and over-estimate count. It is used by the library's characterisation benches and on-chip self-test wrappers.

## Interface
- N_SAMPLES, 256: samples per run; legal range 1..65535.
- SUM_W, 32: width of the sum-of-absolute-error accumulator; legal range 16..48.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a run when sampled high in IDLE; ignored in every other state.
- in_valid  in  1  sample present on in_a/in_b/in_r.
- in_ready  out  1  high only in RUN.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- in_r  in  16  approximate product from the multiplier under test.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- sum_abs_err  out  SUM_W  Σ|in_r − in_a·in_b|, saturating.
- max_abs_err  out  16  max |in_r − in_a·in_b| in the run.
- err_count  out  16  samples with in_r ≠ in_a·in_b.
- over_count  out  16  samples with in_r > in_a·in_b.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE:
  - start=1 clears all four result registers and the sample counter.
  - Next state is RUN.
- RUN:
  - A sample is accepted on an edge where in_valid & in_ready.
  - The accepted sample is captured into stage-1 registers (a, b, r, v1).
  - The sample counter increments on each accept.
  - The accept that makes the count equal N_SAMPLES moves the FSM to DRAIN.
- DRAIN: one cycle. The last stage-1 sample is retired; next state is DONE.
- DONE: done=1 for exactly this cycle; next state is IDLE.
- Results hold their values in IDLE until the next start.
- Stage 2 updates on every edge with v1=1:
  - exact = a·b, 16-bit unsigned.
  - diff = |r − exact|, computed in 17-bit signed and taken as magnitude into 16 bits.
  - sum_abs_err += diff, clamped at 2^SUM_W − 1 with no wrap.
  - max_abs_err = max(max_abs_err, diff).
  - err_count += (diff ≠ 0).
  - over_count += (r > exact).
- Counts cannot overflow because N_SAMPLES ≤ 65535.
- Reset mid-operation: asserting rst_n=0 at any time immediately forces IDLE and zeroes v1, the sample counter and every output. No partial results are retained. A fresh start is required after reset.
- Simultaneous events:
  - start while busy has no effect.
  - in_valid in IDLE, DRAIN or DONE is not accepted; in_ready is low in those states.
- N_SAMPLES=1: the first accept goes straight to DRAIN.

## Timing
- Reset values: in_ready=0, busy=0, done=0, sum_abs_err=0, max_abs_err=0, err_count=0, over_count=0.
- Start to ready: start sampled at edge t → in_ready=1 from the cycle after t.
- Accept to result: a sample accepted at edge t is reflected in the result registers after edge t+1.
- Final sample: last accept at edge t; DRAIN during (t, t+1]; done high during (t+1, t+2]; results are final and stable from edge t+1.
- Throughput: one sample per cycle in RUN, with arbitrary in_valid gaps allowed.
- Outputs are registered; there is no combinational path from inputs to outputs except in_ready, which decodes the state only.

## Test plan
1. **Exact samples.** N_SAMPLES=4, samples (3,5,15), (255,255,65025), (0,7,0), (16,16,256) → sum=0, max=0, err=0, over=0; done pulses 2 cycles after the 4th accept.
2. **Mixed errors.** N_SAMPLES=4, samples (10,10,96), (12,12,150), (255,255,65535), (1,1,1) → sum=520, max=510, err=3, over=2.
3. **Handshake gaps.** in_valid toggled 1,0,1,1,0,1 and a sample driven while in IDLE before start → only the 4 samples accepted in RUN are counted; in_ready=0 in IDLE/DRAIN/DONE; busy high from the cycle after start through DRAIN.
4. **Saturation.** SUM_W=16, N_SAMPLES=4, four samples (255,255,0) → sum_abs_err=65535 (saturated), max=65025, err=4, over=0.
5. **Reset mid-run.** N_SAMPLES=8; rst_n pulsed low after 3 accepts → all outputs 0 immediately, no done pulse; a later start with 8 exact samples gives sum=0, err=0.
6. **Boundaries.** N_SAMPLES=1 with (2,3,7) → sum=1, err=1, over=1, done 2 cycles after the accept. start held high through the whole run → exactly one run, no restart until back in IDLE.
